// File: rtl/das_acq_pkg.sv
// das_acq_pkg: shared state type, default widths and helpers for the DAS
// trace-acquisition sequencer.
package das_acq_pkg;

    localparam int unsigned DATA_W_DEF   = 14;
    localparam int unsigned PERIOD_W_DEF = 24;
    localparam int unsigned LEN_W_DEF    = 16;
    localparam int unsigned PULSE_W_W    = 8;
    localparam int unsigned TRACE_CNT_W  = 32;

    typedef enum logic [2:0] {
        IDLE,
        PULSE,
        DELAY,
        CAPTURE,
        WAIT
    } acq_state_t;

    // A trace is in flight in every state except IDLE and WAIT.
    function automatic logic is_busy(input acq_state_t st);
        return (st != IDLE) && (st != WAIT);
    endfunction

endpackage

// File: rtl/das_acq_out_reg.sv
// das_acq_out_reg: single-entry valid/ready output register. While the held
// beat is stalled (valid && !ready) it keeps its contents; a new beat offered
// in that cycle is dropped and reported on drop.
module das_acq_out_reg
    import das_acq_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    input  logic              m_ready,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic              drop
);

    logic stall;

    assign stall = m_valid && !m_ready;
    assign drop  = s_valid && stall;

    // Load a new beat whenever the register is empty or being drained.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_last  <= 1'b0;
        end else if (!stall) begin
            m_valid <= s_valid;
            m_last  <= s_valid && s_last;
            if (s_valid) begin
                m_data <= s_data;
            end
        end
    end

endmodule

// File: rtl/das_acq_sequencer.sv
// das_acq_sequencer: fires the probe pulse every period_i cycles, waits
// delay_i cycles from the pulse rise, then streams length_i ADC samples with
// a last marker. Optional build macro DAS_ACQ_TEST_PATTERN_EN replaces the
// ADC input with a counter that restarts at every accepted trigger.
module das_acq_sequencer
    import das_acq_pkg::*;
#(
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned PERIOD_W = PERIOD_W_DEF,
    parameter int unsigned LEN_W    = LEN_W_DEF
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   enable_i,
    input  logic [PERIOD_W-1:0]    period_i,
    input  logic [PULSE_W_W-1:0]   pulse_width_i,
    input  logic [LEN_W-1:0]       delay_i,
    input  logic [LEN_W-1:0]       length_i,
    input  logic [DATA_W-1:0]      adc_data_i,
    input  logic                   overflow_clr_i,
    output logic                   pulse_o,
    output logic [DATA_W-1:0]      m_data_o,
    output logic                   m_valid_o,
    output logic                   m_last_o,
    input  logic                   m_ready_i,
    output logic [TRACE_CNT_W-1:0] trace_cnt_o,
    output logic                   overflow_o,
    output logic                   busy_o
);

    // Offset from pulse rise; must hold delay + length (17 bits) and the pulse width.
    localparam int unsigned SEQ_W = LEN_W + 1;

    acq_state_t            state_q;
    logic [PERIOD_W-1:0]   per_q;
    logic [SEQ_W-1:0]      seq_q;
    logic [SEQ_W-1:0]      seq_nxt;
    logic [SEQ_W-1:0]      end_q;
    logic [SEQ_W-1:0]      end_new;
    logic [PULSE_W_W-1:0]  w_q;
    logic [PULSE_W_W-1:0]  w_new;
    logic [LEN_W-1:0]      d_q;
    logic                  pulse_q;
    logic                  busy;
    logic                  trig;
    logic                  start;
    logic                  skip;
    logic                  run_pulse;
    logic                  run_cap;
    logic                  run_pend;
    logic                  cap_last;
    logic [DATA_W-1:0]     sample;
    logic [TRACE_CNT_W-1:0] trace_q;
    logic                  ovf_q;
    logic                  drop;

    // Trigger detection and next-offset decode for the running trace.
    always_comb begin
        busy      = is_busy(state_q);
        trig      = (per_q == '0) && enable_i && (period_i != '0);
        start     = trig && !busy;
        skip      = trig && busy;
        w_new     = (pulse_width_i == '0) ? PULSE_W_W'(1) : pulse_width_i;
        end_new   = (length_i == '0) ? '0 : SEQ_W'(delay_i) + SEQ_W'(length_i);
        seq_nxt   = seq_q + SEQ_W'(1);
        run_pulse = seq_nxt < SEQ_W'(w_q);
        run_cap   = (seq_nxt >= SEQ_W'(d_q)) && (seq_nxt < end_q);
        run_pend  = seq_nxt < end_q;
        cap_last  = (state_q == CAPTURE) && (seq_q == end_q - SEQ_W'(1));
    end

    // Repetition counter: held at 0 while disabled, reloads on every trigger.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            per_q <= '0;
        end else if (!enable_i) begin
            per_q <= '0;
        end else if (trig) begin
            per_q <= period_i - PERIOD_W'(1);
        end else if (per_q != '0) begin
            per_q <= per_q - PERIOD_W'(1);
        end
    end

    // Trace FSM. Pulse and delay/capture run off one shared offset counter so
    // they overlap; the state reports the dominant activity (capture > pulse > delay).
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q <= IDLE;
            seq_q   <= '0;
            w_q     <= '0;
            d_q     <= '0;
            end_q   <= '0;
            pulse_q <= 1'b0;
        end else if (start) begin
            state_q <= ((length_i != '0) && (delay_i == '0)) ? CAPTURE : PULSE;
            seq_q   <= '0;
            w_q     <= w_new;
            d_q     <= delay_i;
            end_q   <= end_new;
            pulse_q <= 1'b1;
        end else begin
            case (state_q)
                PULSE, DELAY, CAPTURE: begin
                    seq_q   <= seq_nxt;
                    pulse_q <= run_pulse;
                    if (run_cap) begin
                        state_q <= CAPTURE;
                    end else if (run_pulse) begin
                        state_q <= PULSE;
                    end else if (run_pend) begin
                        state_q <= DELAY;
                    end else begin
                        state_q <= enable_i ? WAIT : IDLE;
                    end
                end
                WAIT: begin
                    pulse_q <= 1'b0;
                    if (!enable_i) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    pulse_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef DAS_ACQ_TEST_PATTERN_EN
    logic [DATA_W-1:0] pat_q;
    logic              unused_adc;

    assign unused_adc = ^adc_data_i;

    // Pattern source: 0 in the pulse-rise cycle, +1 every cycle after.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            pat_q <= '0;
        end else if (start) begin
            pat_q <= '0;
        end else begin
            pat_q <= pat_q + DATA_W'(1);
        end
    end

    assign sample = pat_q;
`else
    assign sample = adc_data_i;
`endif

    das_acq_out_reg #(
        .DATA_W (DATA_W)
    ) u_out_reg (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .s_valid (state_q == CAPTURE),
        .s_data  (sample),
        .s_last  (cap_last),
        .m_ready (m_ready_i),
        .m_valid (m_valid_o),
        .m_data  (m_data_o),
        .m_last  (m_last_o),
        .drop    (drop)
    );

    // Count a trace when its final sample is captured, even if it was dropped.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            trace_q <= '0;
        end else if (cap_last) begin
            trace_q <= trace_q + TRACE_CNT_W'(1);
        end
    end

    // Sticky overflow; a set event in the same cycle beats the clear.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            ovf_q <= 1'b0;
        end else if (skip || drop) begin
            ovf_q <= 1'b1;
        end else if (overflow_clr_i) begin
            ovf_q <= 1'b0;
        end
    end

    assign pulse_o     = pulse_q;
    assign busy_o      = busy;
    assign trace_cnt_o = trace_q;
    assign overflow_o  = ovf_q;

endmodule

// File: tb/tb_das_acq_sequencer.sv
// tb_das_acq_sequencer: directed bench for das_acq_sequencer. The ADC input
// carries the bench cycle number, so every captured sample is predictable.
module tb_das_acq_sequencer;

    logic        clk_i;
    logic        reset_i;
    logic        enable_i;
    logic [23:0] period_i;
    logic [7:0]  pulse_width_i;
    logic [15:0] delay_i;
    logic [15:0] length_i;
    logic [13:0] adc_data_i;
    logic        overflow_clr_i;
    logic        pulse_o;
    logic [13:0] m_data_o;
    logic        m_valid_o;
    logic        m_last_o;
    logic        m_ready_i;
    logic [31:0] trace_cnt_o;
    logic        overflow_o;
    logic        busy_o;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    das_acq_sequencer #(
        .DATA_W   (14),
        .PERIOD_W (24),
        .LEN_W    (16)
    ) dut (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .enable_i       (enable_i),
        .period_i       (period_i),
        .pulse_width_i  (pulse_width_i),
        .delay_i        (delay_i),
        .length_i       (length_i),
        .adc_data_i     (adc_data_i),
        .overflow_clr_i (overflow_clr_i),
        .pulse_o        (pulse_o),
        .m_data_o       (m_data_o),
        .m_valid_o      (m_valid_o),
        .m_last_o       (m_last_o),
        .m_ready_i      (m_ready_i),
        .trace_cnt_o    (trace_cnt_o),
        .overflow_o     (overflow_o),
        .busy_o         (busy_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d", tag, cyc, got, exp);
        end
    endtask

    // Advance one cycle; the ADC input then carries the new cycle number.
    task automatic step();
        @(posedge clk_i);
        #1;
        cyc++;
        adc_data_i = 14'(cyc);
    endtask

    // Expected sample seen at offset rr after a trigger in cycle tcyc.
    function automatic logic [13:0] beat_val(input int tcyc, input int rr);
`ifdef DAS_ACQ_TEST_PATTERN_EN
        return 14'(rr - 2);
`else
        return 14'(tcyc + rr - 1);
`endif
    endfunction

    task automatic arm(input int p, input int w, input int d, input int l, output int tc);
        step();
        period_i      = 24'(p);
        pulse_width_i = 8'(w);
        delay_i       = 16'(d);
        length_i      = 16'(l);
        enable_i      = 1'b1;
        tc            = cyc;
    endtask

    // Cycle-by-cycle expectation for ntrig evenly spaced accepted triggers
    // starting in cycle tc (ready held high).
    task automatic watch(input int tc, input int ncyc, input int p, input int w,
                         input int d, input int l, input int ntrig, input int base);
        int weff, endv, span, tr, rr, nlast;
        logic ev;
        weff = (w == 0) ? 1 : w;
        endv = (l == 0) ? 0 : d + l;
        span = (weff > endv) ? weff : endv;
        for (int r = 0; r < ncyc; r++) begin
            tr = r / p;
            if (tr > ntrig - 1) tr = ntrig - 1;
            rr = r - tr * p;
            nlast = 0;
            if (l != 0) begin
                for (int i = 0; i < ntrig; i++) begin
                    if (i * p + d + l + 1 <= r) nlast++;
                end
            end
            ev = (l != 0) && (rr >= d + 2) && (rr <= d + l + 1);
            check("pulse", 32'(pulse_o), 32'(rr >= 1 && rr <= weff));
            check("valid", 32'(m_valid_o), 32'(ev));
            check("last", 32'(m_last_o), 32'(ev && (rr == d + l + 1)));
            if (ev) check("data", 32'(m_data_o), 32'(beat_val(tc + tr * p, rr)));
            check("busy", 32'(busy_o), 32'(rr >= 1 && rr <= span));
            check("trace_cnt", trace_cnt_o, 32'(base + nlast));
            step();
        end
    endtask

    task automatic goto_r(input int tc, input int r);
        while (cyc < tc + r) step();
    endtask

    initial begin
        int tc;
        reset_i        = 1'b0;
        enable_i       = 1'b0;
        period_i       = '0;
        pulse_width_i  = '0;
        delay_i        = '0;
        length_i       = '0;
        adc_data_i     = '0;
        overflow_clr_i = 1'b0;
        m_ready_i      = 1'b1;

        // Reset state
        repeat (3) step();
        check("rst_pulse", 32'(pulse_o), 32'd0);
        check("rst_valid", 32'(m_valid_o), 32'd0);
        check("rst_last", 32'(m_last_o), 32'd0);
        check("rst_data", 32'(m_data_o), 32'd0);
        check("rst_cnt", trace_cnt_o, 32'd0);
        check("rst_ovf", 32'(overflow_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        reset_i = 1'b1;
        repeat (2) step();

        // Single trace: P=100 W=4 D=10 L=8
        arm(100, 4, 10, 8, tc);
        watch(tc, 100, 100, 4, 10, 8, 1, 0);
        enable_i = 1'b0;
        check("t1_ovf", 32'(overflow_o), 32'd0);

        // Five consecutive periods
        arm(100, 4, 10, 8, tc);
        watch(tc, 500, 100, 4, 10, 8, 5, 1);
        enable_i = 1'b0;
        check("t2_ovf", 32'(overflow_o), 32'd0);

        // Downstream stalled for the whole trace
        m_ready_i = 1'b0;
        arm(100, 4, 10, 8, tc);
        goto_r(tc, 12);
        check("hold_valid0", 32'(m_valid_o), 32'd1);
        check("hold_data0", 32'(m_data_o), 32'(beat_val(tc, 12)));
        check("hold_ovf0", 32'(overflow_o), 32'd0);
        goto_r(tc, 13);
        check("hold_ovf1", 32'(overflow_o), 32'd1);
        goto_r(tc, 25);
        check("hold_valid", 32'(m_valid_o), 32'd1);
        check("hold_data", 32'(m_data_o), 32'(beat_val(tc, 12)));
        check("hold_last", 32'(m_last_o), 32'd0);
        check("hold_cnt", trace_cnt_o, 32'd7);
        goto_r(tc, 30);
        m_ready_i = 1'b1;
        step();
        check("drain_valid", 32'(m_valid_o), 32'd0);
        overflow_clr_i = 1'b1;
        check("clr_ovf_before", 32'(overflow_o), 32'd1);
        step();
        overflow_clr_i = 1'b0;
        check("clr_ovf_after", 32'(overflow_o), 32'd0);
        goto_r(tc, 40);
        enable_i = 1'b0;

        // Period too short: every second trigger skipped
        arm(10, 2, 5, 8, tc);
        watch(tc, 80, 20, 2, 5, 8, 4, 7);
        enable_i = 1'b0;
        check("skip_ovf", 32'(overflow_o), 32'd1);
        overflow_clr_i = 1'b1;
        step();
        overflow_clr_i = 1'b0;
        check("skip_clr", 32'(overflow_o), 32'd0);

        // Zero delay: capture starts with the pulse rise
        arm(20, 2, 0, 4, tc);
        watch(tc, 40, 20, 2, 0, 4, 2, 11);
        enable_i = 1'b0;
        check("d0_ovf", 32'(overflow_o), 32'd0);

        // Zero length and zero pulse width (treated as 1)
        arm(50, 0, 10, 0, tc);
        watch(tc, 100, 50, 0, 10, 0, 2, 13);
        enable_i = 1'b0;
        check("l0_ovf", 32'(overflow_o), 32'd0);

        // Zero period: sequencer stays idle
        arm(0, 4, 10, 8, tc);
        for (int r = 0; r < 60; r++) begin
            check("p0_pulse", 32'(pulse_o), 32'd0);
            check("p0_busy", 32'(busy_o), 32'd0);
            step();
        end
        enable_i = 1'b0;

        // Reset mid-capture, then a clean restart
        arm(100, 4, 10, 8, tc);
        goto_r(tc, 14);
        check("pre_rst_valid", 32'(m_valid_o), 32'd1);
        reset_i = 1'b0;
        #1;
        check("mid_rst_pulse", 32'(pulse_o), 32'd0);
        check("mid_rst_valid", 32'(m_valid_o), 32'd0);
        check("mid_rst_last", 32'(m_last_o), 32'd0);
        check("mid_rst_data", 32'(m_data_o), 32'd0);
        check("mid_rst_cnt", trace_cnt_o, 32'd0);
        check("mid_rst_busy", 32'(busy_o), 32'd0);
        check("mid_rst_ovf", 32'(overflow_o), 32'd0);
        repeat (2) step();
        reset_i = 1'b1;
        tc = cyc;
        watch(tc, 100, 100, 4, 10, 8, 1, 0);
        enable_i = 1'b0;
        check("restart_ovf", 32'(overflow_o), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
